nibble_serial_cmp_ctrl: RTL
===========================

Name: nibble_serial_cmp_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands by stepping one 4-bit slice at a time through a single shared 4-bit magnitude-comparator datapath.
- Scans MSB nibble first, in the style of a cascade of 74LS85 comparators, but time-multiplexed onto one comparator.
- Provides a start/busy/done handshake and registered held results.
- Sits between wide-operand emulator logic and the 4-bit comparator slice.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.
- IDX_W, derived, equals max(1, clog2(N)); width of the nibble index.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a comparison; sampled only while busy=0.
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
- done  output  1  one-cycle pulse when the result is valid.
- a_gt_b  output  1  registered A>B result, held until the next done.
- a_lt_b  output  1  registered A<B result, held until the next done.
- a_eq_b  output  1  registered A=B result, held until the next done.
- nib_idx  output  IDX_W  nibble currently being compared (debug/observe).

Behaviour:
- Reset is synchronous: rst_n=0 at a rising edge forces IDLE and sets busy, done, a_gt_b, a_lt_b, a_eq_b and nib_idx to 0. This applies mid-RUN too; the in-flight comparison is discarded with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 captures a_in/b_in into a_q/b_q, sets nib_idx=N-1 and clears the decided flag, then moves to RUN.
  - start=0 stays in IDLE.
- RUN: each cycle compares a_q[4*idx+3:4*idx] against b_q[4*idx+3:4*idx] as unsigned 4-bit values.
  - Unequal nibble: records gt/lt from that nibble, enters DONE (early exit).
  - Equal nibble and idx=0: records eq, enters DONE.
  - Equal nibble and idx>0: decrements idx.
- DONE: done=1 for exactly one cycle; the result registers take the new value on entry to DONE. Next state is IDLE.
- Result outputs are one-hot after the first completed comparison and all-zero only after reset. They change only on DONE entry.
- Latency: with start sampled at edge 0 and k nibbles examined (1..N), done is high in the cycle following edge k. Back-to-back throughput is one comparison per k+2 cycles.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- a_in/b_in changes after capture have no effect on an ongoing comparison.
- nib_idx holds its last value in IDLE/DONE.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: early-exit behaviour as above; k = index distance to the first unequal nibble + 1, or N if all nibbles are equal.
- Undefined: constant-time mode. RUN always visits all N nibbles (k=N). The first unequal nibble, MSB-first, sets a decided flag and latches gt/lt; later nibbles are ignored. Results are identical to the defined case; only timing differs.

Decomposition:
- Shared package cmp_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - NIB_W=4 constant.
  - A cmp_res_t typedef {gt, lt, eq}.
- One natural sub-module: nibble_cmp4, a combinational 4-bit unsigned magnitude comparator returning cmp_res_t. It is the shared datapath the controller sequences.

Test Plan:
- WIDTH=16, A=0x1234, B=0x1234 -> a_eq_b=1, gt=lt=0; done in the cycle after edge 4 (k=4), busy high for 5 cycles.
- WIDTH=16, A=0x9000, B=0x4FFF -> a_gt_b=1.
  - With CMP_EARLY_EXIT_EN: done after edge 1, nib_idx=3 at done.
  - Without the macro: done after edge 4, same result.
- WIDTH=16, A=0x00A0, B=0x00A9 -> a_lt_b=1; decided at nib_idx=0, done after edge 4 in both modes.
- Start A=0x0001,B=0x0002; pulse start again at edges 2 and at the DONE cycle with A=0xFFFF,B=0 -> both ignored; result stays lt and done pulses once.
- Start A=0x1111,B=0x1111, then rst_n=0 at edge 2 -> next cycle busy=0, all results 0, no done pulse. Then a fresh start with A=10,B=9 (WIDTH=4 instance) -> a_gt_b=1, done after edge 1.
- WIDTH=4 instance, sequence (0,0),(4,9),(10,9),(10,10),(11,10),(14,14) -> eq, lt, gt, eq, gt, eq respectively; each done one cycle after the RUN edge.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM state, nibble width and comparator result types
package cmp_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;
endpackage

// File: rtl/nibble_cmp4.sv
// nibble_cmp4: combinational 4-bit unsigned magnitude comparator
module nibble_cmp4
  import cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output cmp_res_t         r
);
  always_comb begin
    r.gt = a > b;
    r.lt = a < b;
    r.eq = a == b;
  end
endmodule

// File: rtl/nibble_serial_cmp_ctrl.sv
// nibble_serial_cmp_ctrl: MSB-first nibble-serial wide comparator controller; define CMP_EARLY_EXIT_EN to stop at the first unequal nibble
module nibble_serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int N     = WIDTH / NIB_W,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [IDX_W-1:0] nib_idx
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec_q, dec_d;
  cmp_res_t         pend_q, pend_d, res_q, res_d, cur;
  logic             last;
  nibble_cmp4 u_cmp (
    .a(a_q[idx_q*NIB_W +: NIB_W]),
    .b(b_q[idx_q*NIB_W +: NIB_W]),
    .r(cur)
  );
`ifdef CMP_EARLY_EXIT_EN
  assign last = !cur.eq || idx_q == '0;
`else
  assign last = idx_q == '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      pend_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    pend_d  = pend_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        idx_d   = IDX_W'(N - 1);
        dec_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (!dec_q && !cur.eq) begin
          dec_d  = 1'b1;
          pend_d = cur;
        end
        if (last) begin
          res_d   = dec_q ? pend_q : cur;
          state_d = DONE;
        end else
          idx_d = idx_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy                     = state_q != IDLE;
    done                     = state_q == DONE;
    {a_gt_b, a_lt_b, a_eq_b} = res_q;
    nib_idx                  = idx_q;
  end
endmodule
